// File: rtl/feeder_pkg.sv
// Shared types and constants for the allophone feeder.
// State encoding, allophone width and the PA1 pause code.
package feeder_pkg;

  localparam int ALLO_W = 6;
  localparam logic [ALLO_W-1:0] ALLO_PA1 = 6'd0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/allophone_feeder_if.sv
// Host bus plus controller load handshake of the allophone feeder.
// master = host/controller side, slave = feeder.
interface allophone_feeder_if
  import feeder_pkg::*;
#(
  parameter int AW = 4
);

  logic [ALLO_W-1:0] host_data;
  logic              host_wr;
  logic              host_flush;
  logic              host_full;
  logic              host_empty;
  logic [AW:0]       host_count;
  logic              ldq;
  logic [ALLO_W-1:0] data_out;
  logic              data_stb;
  logic              busy;
  logic              ack_err;

  modport master (
    output host_data, host_wr, host_flush, ldq,
    input  host_full, host_empty, host_count,
    input  data_out, data_stb, busy, ack_err
  );

  modport slave (
    input  host_data, host_wr, host_flush, ldq,
    output host_full, host_empty, host_count,
    output data_out, data_stb, busy, ack_err
  );

endinterface

// File: rtl/feeder_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// Flush wins over push/pop; full is judged before a same-cycle pop.
module feeder_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  input  logic          flush,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr & ~full & ~flush;
  assign pop   = rd & ~empty & ~flush;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/allophone_feeder.sv
// Feeds queued allophones to the controller on its ldq request.
// FEEDER_SILENCE_EN: append one PA1 pause after the queue drains.
module allophone_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int STB_LEN     = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  allophone_feeder_if.slave bus
);

  state_t            state;
  state_t            nxt;
  logic [3:0]        stb_cnt;
  logic [7:0]        to_cnt;
  logic [ALLO_W-1:0] head;
  logic [ALLO_W-1:0] dout;
  logic              err;
  logic              have_code;
  logic              want_sil;
  logic              stb_done;
  logic              to_done;
  logic              pop;
  logic              sil;
  logic              load;
  logic              timeout;

  feeder_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (ALLO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (bus.host_wr),
    .wdata (bus.host_data),
    .rd    (pop),
    .flush (bus.host_flush),
    .rdata (head),
    .full  (bus.host_full),
    .empty (bus.host_empty),
    .count (bus.host_count)
  );

  assign have_code = bus.ldq & ~bus.host_empty;
  assign stb_done  = (stb_cnt == 4'(STB_LEN - 1));
  assign to_done   = (to_cnt == 8'(ACK_TIMEOUT - 1));

`ifdef FEEDER_SILENCE_EN
  logic armed;

  // A same-cycle host write beats the pause insertion.
  assign want_sil = bus.ldq & bus.host_empty
                  & armed & ~bus.host_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      armed <= 1'b0;
    else if (sil) armed <= 1'b0;
    else if (pop) armed <= 1'b1;
  end
`else
  assign want_sil = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (have_code | want_sil) nxt = ST_STROBE;
      ST_STROBE:
        if (stb_done) nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:
        if (!bus.ldq || to_done) nxt = ST_IDLE;
      default:
        nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    sil     = 1'b0;
    load    = 1'b0;
    timeout = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        pop  = have_code;
        sil  = ~have_code & want_sil;
        load = have_code | want_sil;
      end
      (state == ST_WAIT_ACK):
        timeout = bus.ldq & to_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= '0;
      err     <= 1'b0;
      stb_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (load) dout <= sil ? ALLO_PA1 : head;
      if (timeout)             err <= 1'b1;
      else if (bus.host_flush) err <= 1'b0;
      stb_cnt <= (state == ST_STROBE) ? stb_cnt + 1'b1 : '0;
      to_cnt  <= (state == ST_WAIT_ACK) ? to_cnt + 1'b1 : '0;
    end
  end

  assign bus.data_out = dout;
  assign bus.ack_err  = err;
  assign bus.data_stb = (state == ST_STROBE);
  assign bus.busy     = ~bus.host_empty | (state != ST_IDLE);

endmodule

// File: tb/tb_allophone_feeder.sv
// Directed bench for allophone_feeder (default params).
// Covers FEEDER_SILENCE_EN defined or undefined.
module tb_allophone_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   stb_seen = 0;

  always #5 clk = ~clk;

  allophone_feeder_if #(.AW(4)) bus ();

  allophone_feeder #(
    .DEPTH       (16),
    .AW          (4),
    .STB_LEN     (1),
    .ACK_TIMEOUT (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.data_stb === 1'b1) stb_seen++;
  endtask

  task automatic push(input logic [5:0] v);
    bus.host_data = v;
    bus.host_wr   = 1'b1;
    tick();
    bus.host_wr   = 1'b0;
  endtask

  task automatic handshake(input logic [5:0] exp, input string nm);
    bus.ldq = 1'b1;
    tick();
    checks++;
    if (bus.data_stb !== 1'b1 || bus.data_out !== exp) begin
      errs++;
      $display("FAIL %s strobe: stb=%b data=%0d want stb=1 data=%0d",
               nm, bus.data_stb, bus.data_out, exp);
    end
    tick();
    checks++;
    if (bus.data_stb !== 1'b0 || bus.data_out !== exp) begin
      errs++;
      $display("FAIL %s width: stb=%b data=%0d want stb=0 data=%0d",
               nm, bus.data_stb, bus.data_out, exp);
    end
    repeat (3) tick();
    bus.ldq = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.host_empty !== 1'b1 || bus.host_full !== 1'b0 ||
        bus.host_count !== 5'd0 || bus.data_out !== 6'd0 ||
        bus.data_stb !== 1'b0 || bus.busy !== 1'b0 ||
        bus.ack_err !== 1'b0) begin
      errs++;
      $display("FAIL reset: e=%b f=%b c=%0d d=%0d s=%b b=%b a=%b want 1 0 0 0 0 0 0",
               bus.host_empty, bus.host_full, bus.host_count,
               bus.data_out, bus.data_stb, bus.busy, bus.ack_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_queue();
    stb_seen = 0;
    push(6'd6);
    push(6'd17);
    push(6'd42);
    repeat (3) tick();
    checks++;
    if (bus.host_count !== 5'd3 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL queue: count=%0d busy=%b want count=3 busy=1",
               bus.host_count, bus.busy);
    end
    checks++;
    if (stb_seen !== 0) begin
      errs++;
      $display("FAIL queue_nostb: strobes=%0d want 0", stb_seen);
    end
  endtask

  task automatic test_handshake();
    stb_seen = 0;
    handshake(6'd6, "hs0");
    handshake(6'd17, "hs1");
    handshake(6'd42, "hs2");
    checks++;
    if (bus.host_empty !== 1'b1 || bus.busy !== 1'b0 ||
        stb_seen !== 3) begin
      errs++;
      $display("FAIL hs_end: empty=%b busy=%b strobes=%0d want 1 0 3",
               bus.host_empty, bus.busy, stb_seen);
    end
  endtask

  task automatic test_fill_drain(input int base);
    for (int i = 0; i < 17; i++) push(6'(base + i));
    checks++;
    if (bus.host_full !== 1'b1 || bus.host_count !== 5'd16) begin
      errs++;
      $display("FAIL fill%0d: full=%b count=%0d want full=1 count=16",
               base, bus.host_full, bus.host_count);
    end
    for (int i = 0; i < 16; i++)
      handshake(6'(base + i), $sformatf("drain%0d_%0d", base, i));
    checks++;
    if (bus.host_empty !== 1'b1 || bus.host_count !== 5'd0) begin
      errs++;
      $display("FAIL drain%0d: empty=%b count=%0d want 1 0",
               base, bus.host_empty, bus.host_count);
    end
  endtask

  task automatic test_timeout();
    push(6'd50);
    push(6'd51);
    bus.ldq = 1'b1;
    tick();
    checks++;
    if (bus.data_stb !== 1'b1 || bus.data_out !== 6'd50) begin
      errs++;
      $display("FAIL to_stb1: stb=%b data=%0d want 1 50",
               bus.data_stb, bus.data_out);
    end
    tick();
    repeat (254) tick();
    checks++;
    if (bus.ack_err !== 1'b0) begin
      errs++;
      $display("FAIL to_early: ack_err=%b want 0", bus.ack_err);
    end
    tick();
    checks++;
    if (bus.ack_err !== 1'b1 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL to_set: ack_err=%b busy=%b want 1 1",
               bus.ack_err, bus.busy);
    end
    tick();
    checks++;
    if (bus.data_stb !== 1'b1 || bus.data_out !== 6'd51) begin
      errs++;
      $display("FAIL to_stb2: stb=%b data=%0d want 1 51",
               bus.data_stb, bus.data_out);
    end
    bus.ldq = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.ack_err !== 1'b1) begin
      errs++;
      $display("FAIL to_sticky: ack_err=%b want 1", bus.ack_err);
    end
    bus.host_flush = 1'b1;
    tick();
    bus.host_flush = 1'b0;
    checks++;
    if (bus.ack_err !== 1'b0 || bus.host_empty !== 1'b1) begin
      errs++;
      $display("FAIL to_clear: ack_err=%b empty=%b want 0 1",
               bus.ack_err, bus.host_empty);
    end
  endtask

  task automatic test_async_reset();
    push(6'd7);
    push(6'd8);
    bus.ldq = 1'b1;
    tick();
    checks++;
    if (bus.data_stb !== 1'b1 || bus.data_out !== 6'd7) begin
      errs++;
      $display("FAIL rst_pre: stb=%b data=%0d want 1 7",
               bus.data_stb, bus.data_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.data_stb !== 1'b0 || bus.host_count !== 5'd0 ||
        bus.data_out !== 6'd0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: stb=%b count=%0d data=%0d busy=%b want 0 0 0 0",
               bus.data_stb, bus.host_count, bus.data_out, bus.busy);
    end
    #1 rst = 1'b0;
    bus.ldq = 1'b0;
    tick();
    push(6'd9);
    bus.host_data  = 6'd10;
    bus.host_wr    = 1'b1;
    bus.host_flush = 1'b1;
    tick();
    bus.host_wr    = 1'b0;
    bus.host_flush = 1'b0;
    checks++;
    if (bus.host_count !== 5'd0 || bus.host_empty !== 1'b1) begin
      errs++;
      $display("FAIL flush_wr: count=%0d empty=%b want 0 1",
               bus.host_count, bus.host_empty);
    end
  endtask

  task automatic test_silence();
    push(6'd6);
    handshake(6'd6, "sil_code");
    stb_seen = 0;
    bus.ldq = 1'b1;
`ifdef FEEDER_SILENCE_EN
    tick();
    checks++;
    if (bus.data_stb !== 1'b1 || bus.data_out !== 6'd0) begin
      errs++;
      $display("FAIL sil_pa1: stb=%b data=%0d want 1 0",
               bus.data_stb, bus.data_out);
    end
    repeat (3) tick();
    bus.ldq = 1'b0;
    repeat (5) tick();
    bus.ldq = 1'b1;
    repeat (10) tick();
    checks++;
    if (stb_seen !== 1 || bus.data_out !== 6'd0) begin
      errs++;
      $display("FAIL sil_once: strobes=%0d data=%0d want 1 0",
               stb_seen, bus.data_out);
    end
`else
    repeat (10) tick();
    checks++;
    if (stb_seen !== 0 || bus.data_out !== 6'd6 ||
        bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL sil_none: strobes=%0d data=%0d busy=%b want 0 6 0",
               stb_seen, bus.data_out, bus.busy);
    end
`endif
    bus.ldq = 1'b0;
    tick();
  endtask

  initial begin
    bus.host_data  = '0;
    bus.host_wr    = 1'b0;
    bus.host_flush = 1'b0;
    bus.ldq        = 1'b0;
    #12;
    test_reset();
    test_queue();
    test_handshake();
    test_fill_drain(1);
    test_fill_drain(20);
    test_timeout();
    test_async_reset();
    test_silence();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1);
  end

endmodule
